uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
//   Configurable data width (LSB first), parity mode, stop-bit count and
//   oversampling ratio. The asynchronous rx line is brought in through a
//   2-FF synchroniser. The receiver rejects false starts and reports
//   parity/framing errors alongside each delivered word.
//   Optional build macro UART_RX_MAJORITY_EN: when defined, every bit
//   decision is the 2-of-3 majority of the synchronised line, sampled on
//   the ticks with cnt = D-2, D-1 and D. When undefined, a single sample
//   is taken on the decision tick. Frame timing, latency and ports are
//   the same in both builds.
module uart_rx_cfg #(
    parameter int NB_DATA      = 8,   // 5..9 data bits, LSB first
    parameter int NB_STOP_BITS = 1,   // 1 or 2
    parameter int PARITY_MODE  = 0,   // 0 = none, 1 = even, 2 = odd
    parameter int OVERSAMPLE   = 16   // ticks per bit, even, >= 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = 4;

    // Decision points: middle of the start bit counted from the detected
    // falling edge, then one full bit period for every later bit.
    localparam logic [CW-1:0] START_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_MID   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(NB_DATA - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(NB_STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [BW-1:0]       bitcnt_reg, bitcnt_next;
    logic [NB_DATA-1:0]  shift_reg, shift_next;
    logic                par_err_reg, par_err_next;
    logic                frame_err_reg, frame_err_next;
    logic [NB_DATA-1:0]  data_out_reg, data_out_next;
    logic                rxdone_reg, rxdone_next;
    logic                par_out_reg, par_out_next;
    logic                frame_out_reg, frame_out_next;
    logic [1:0]          sync_reg;
    logic                rxs;
    logic                bit_val;
    logic                par_expected;
    logic                frame_now;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], i_data};
        end
    end

    assign rxs = sync_reg[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_reg;

    // Keep the two previous tick samples so that, on the decision tick,
    // hist_reg holds the samples from cnt = D-2 and cnt = D-1.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            hist_reg <= 2'b11;
        end else if (i_tick && (state_reg != IDLE)) begin
            hist_reg <= {hist_reg[0], rxs};
        end
    end

    assign bit_val = (hist_reg[1] & hist_reg[0]) |
                     (hist_reg[1] & rxs) |
                     (hist_reg[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    // Parity bit the transmitter should have sent for the assembled word.
    assign par_expected = (PARITY_MODE == 1) ? (^shift_reg) : (~^shift_reg);

    // Framing status including the stop bit being decided right now.
    assign frame_now = frame_err_reg | ~bit_val;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bitcnt_reg    <= '0;
            shift_reg     <= '0;
            par_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            data_out_reg  <= '0;
            rxdone_reg    <= 1'b0;
            par_out_reg   <= 1'b0;
            frame_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bitcnt_reg    <= bitcnt_next;
            shift_reg     <= shift_next;
            par_err_reg   <= par_err_next;
            frame_err_reg <= frame_err_next;
            data_out_reg  <= data_out_next;
            rxdone_reg    <= rxdone_next;
            par_out_reg   <= par_out_next;
            frame_out_reg <= frame_out_next;
        end
    end

    // Next-state logic: bit sequencing, sampling and frame delivery.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bitcnt_next    = bitcnt_reg;
        shift_next     = shift_reg;
        par_err_next   = par_err_reg;
        frame_err_next = frame_err_reg;
        data_out_next  = data_out_reg;
        rxdone_next    = 1'b0;
        par_out_next   = par_out_reg;
        frame_out_next = frame_out_reg;

        case (state_reg)
            IDLE: begin
                // Edge detection needs no tick; error accumulators start fresh.
                if (!rxs) begin
                    state_next     = START;
                    cnt_next       = '0;
                    bitcnt_next    = '0;
                    par_err_next   = 1'b0;
                    frame_err_next = 1'b0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (cnt_reg == START_MID) begin
                        cnt_next    = '0;
                        bitcnt_next = '0;
                        if (bit_val) begin
                            // Line went back high: a glitch, not a frame.
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (cnt_reg == BIT_MID) begin
                        shift_next = {bit_val, shift_reg[NB_DATA-1:1]};
                        cnt_next   = '0;
                        if (bitcnt_reg == LAST_DATA) begin
                            bitcnt_next = '0;
                            state_next  = (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bitcnt_next = bitcnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (i_tick) begin
                    if (cnt_reg == BIT_MID) begin
                        par_err_next = (bit_val != par_expected);
                        cnt_next     = '0;
                        bitcnt_next  = '0;
                        state_next   = STOP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            STOP: begin
                if (i_tick) begin
                    if (cnt_reg == BIT_MID) begin
                        cnt_next       = '0;
                        frame_err_next = frame_now;
                        if (bitcnt_reg == LAST_STOP) begin
                            // Leave at mid-stop so a following start edge is caught.
                            bitcnt_next    = '0;
                            state_next     = IDLE;
                            rxdone_next    = 1'b1;
                            data_out_next  = shift_reg;
                            par_out_next   = par_err_reg;
                            frame_out_next = frame_now;
                        end else begin
                            bitcnt_next = bitcnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_data       = data_out_reg;
    assign o_rxdone     = rxdone_reg;
    assign o_parity_err = par_out_reg;
    assign o_frame_err  = frame_out_reg;
    assign o_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized + directed frames for uart_rx_cfg (8E2, x16).
//   Stimulus pushes the expected word/flags into a queue; a monitor pops and
//   compares on every o_rxdone pulse.
module tb_uart_rx_cfg;

    localparam int NB_DATA  = 8;
    localparam int NB_STOP  = 2;
    localparam int PMODE    = 1;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;

    logic               clk = 1'b0;
    logic               i_rst;
    logic               i_tick;
    logic               i_data;
    logic [NB_DATA-1:0] o_data;
    logic               o_rxdone;
    logic               o_parity_err;
    logic               o_frame_err;
    logic               o_busy;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .NB_DATA     (NB_DATA),
        .NB_STOP_BITS(NB_STOP),
        .PARITY_MODE (PMODE),
        .OVERSAMPLE  (OS)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_tick      (i_tick),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_rxdone    (o_rxdone),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    typedef struct {
        logic [NB_DATA-1:0] data;
        logic               perr;
        logic               ferr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks          = 0;
    int   passes          = 0;
    int   pulses          = 0;
    int   expected_frames = 0;
    logic busy_seen       = 1'b0;
    logic prev_done       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Parity bit a correct transmitter sends for d.
    function automatic logic good_parity(input logic [NB_DATA-1:0] d);
        int ones = $countones(d);
        if (PMODE == 2) return ((ones % 2) == 0);
        return ((ones % 2) == 1);
    endfunction

    // Reference: word as sent, parity error if the sent bit disagrees with
    // the rule, framing error if any stop bit was 0.
    function automatic exp_t model(input logic [NB_DATA-1:0] d, input logic pbit,
                                   input logic [NB_STOP-1:0] stops);
        exp_t r;
        r.data = d;
        r.perr = (PMODE == 0) ? 1'b0 : (pbit != good_parity(d));
        r.ferr = (stops != {NB_STOP{1'b1}});
        return r;
    endfunction

    // Oversample tick: one clk high every TICK_DIV clks.
    initial begin
        i_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            i_tick = 1'b1;
            @(negedge clk);
            i_tick = 1'b0;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_busy) busy_seen = 1'b1;
            if (o_rxdone) begin
                pulses++;
                $display("rx frame %0d: data=0x%02h parity_err=%0b frame_err=%0b",
                         pulses, o_data, o_parity_err, o_frame_err);
                check("rxdone_single_clk", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rxdone: got data 0x%0h, expected no frame", o_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data", {24'd0, o_data}, {24'd0, mon_e.data});
                    check("parity_err", {31'd0, o_parity_err}, {31'd0, mon_e.perr});
                    check("frame_err", {31'd0, o_frame_err}, {31'd0, mon_e.ferr});
                end
            end
        end
        prev_done = o_rxdone;
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    task automatic wait_tick();
        do @(posedge clk); while (i_tick !== 1'b1);
        #1;
    endtask

    task automatic hold_bit(input logic b, input int n);
        i_data = b;
        repeat (n) wait_tick();
    endtask

    // A low final stop bit is cut short so the receiver's re-armed start
    // detection sees a clean high line at its decision point.
    task automatic send_frame(input logic [NB_DATA-1:0] d, input logic pbit,
                              input logic [NB_STOP-1:0] stops, input int gap);
        int g = gap;
        exp_q.push_back(model(d, pbit, stops));
        expected_frames++;
        hold_bit(1'b0, OS);
        for (int i = 0; i < NB_DATA; i++) hold_bit(d[i], OS);
        if (PMODE != 0) hold_bit(pbit, OS);
        for (int s = 0; s < NB_STOP; s++) begin
            if (s == NB_STOP - 1 && !stops[s]) begin
                hold_bit(1'b0, (OS * 5) / 8);
                if (g < 2 * OS) g = 2 * OS;
            end else begin
                hold_bit(stops[s], OS);
            end
        end
        hold_bit(1'b1, g);
    endtask

    initial begin
        logic [NB_DATA-1:0] d;
        int pulses_before;
        int w;

        i_rst  = 1'b1;
        i_data = 1'b1;
        repeat (5) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check("reset_data", {24'd0, o_data}, 32'd0);
        check("reset_rxdone", {31'd0, o_rxdone}, 32'd0);
        check("reset_parity_err", {31'd0, o_parity_err}, 32'd0);
        check("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        hold_bit(1'b1, 20);

        // Clean frame, parity error then clean, framing errors.
        send_frame(8'hA5, good_parity(8'hA5), 2'b11, 10);
        send_frame(8'h3C, 1'b1, 2'b11, 10);
        send_frame(8'h3C, 1'b0, 2'b11, 10);
        send_frame(8'h55, good_parity(8'h55), 2'b10, 10);
        send_frame(8'h55, good_parity(8'h55), 2'b01, 10);

        // Short low glitch: busy pulses, nothing delivered, outputs hold.
        busy_seen     = 1'b0;
        pulses_before = pulses;
        hold_bit(1'b0, 4);
        hold_bit(1'b1, 3 * OS);
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_busy_idle", {31'd0, o_busy}, 32'd0);
        check("glitch_no_pulse", pulses, pulses_before);
        check("glitch_data_hold", {24'd0, o_data}, 32'h55);

        // Back-to-back frames.
        send_frame(8'h01, good_parity(8'h01), 2'b11, 0);
        send_frame(8'hFE, good_parity(8'hFE), 2'b11, 10);

        // Reset in the middle of data bit 3 aborts the frame.
        d = 8'hC3;
        hold_bit(1'b0, OS);
        for (int i = 0; i < 3; i++) hold_bit(d[i], OS);
        hold_bit(d[3], OS / 2);
        @(negedge clk);
        i_rst  = 1'b1;
        i_data = 1'b1;
        @(negedge clk);
        check("rst_mid_data", {24'd0, o_data}, 32'd0);
        check("rst_mid_rxdone", {31'd0, o_rxdone}, 32'd0);
        check("rst_mid_parity_err", {31'd0, o_parity_err}, 32'd0);
        check("rst_mid_frame_err", {31'd0, o_frame_err}, 32'd0);
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b0;
        hold_bit(1'b1, 2 * OS);
        send_frame(8'h81, good_parity(8'h81), 2'b11, 10);

        // Randomized frames with occasional parity/stop faults.
        for (int n = 0; n < 16; n++) begin
            logic [NB_STOP-1:0] stops;
            logic pbit;
            d     = NB_DATA'($urandom);
            pbit  = good_parity(d) ^ ($urandom_range(0, 3) == 0);
            for (int s = 0; s < NB_STOP; s++) stops[s] = ($urandom_range(0, 4) != 0);
            send_frame(d, pbit, stops, int'($urandom_range(0, 24)));
        end

        w = 0;
        while (exp_q.size() != 0 && w < OS * TICK_DIV * 4) begin
            @(negedge clk);
            w++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
        check("pulse_count", pulses, expected_frames);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
